// File: rtl/uart_rx_fifo_mmio.sv
// uart_rx_fifo_mmio: memory-mapped 8N1 UART receiver with byte FIFO and fill-level interrupt
module uart_rx_fifo_mmio #(
  parameter int          DEFAULT_DIV = 50,
  parameter int          FIFO_AW     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0010
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  input  logic        rxd,
  output logic        irq
);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic r1, r2, r3;
  logic [15:0] div, d, d_n, cc, cc_n;
  logic [2:0] bc, bc_n;
  logic [7:0] sh, sh_n;
  logic fw, fw_n, push, ferr_set;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0] count;
  logic [4:0] thresh;
  logic ovr, ferr;
  logic sel, req, wr, pop, full, empty, acc;
  logic [1:0] a;
  logic [31:0] rmux;
  logic unused;
  assign unused = ^{mem_addr[1:0], mem_wdata[31:16]};
  assign sel = mem_valid && mem_addr[31:4] == BASE_ADDR[31:4];
  assign req = sel && !mem_ready;
  assign wr = |mem_wstrb;
  assign a = mem_addr[3:2];
  assign full = count == (FIFO_AW+1)'(DEPTH);
  assign empty = count == '0;
  assign pop = req && !wr && a == 2'd0 && !empty;
  // a pop on the same edge frees the slot, so a push into a full FIFO still lands
  assign acc = push && (!full || pop);
  always_comb begin
    state_n = state;
    cc_n = cc + 16'd1;
    bc_n = bc;
    sh_n = sh;
    d_n = d;
    fw_n = fw;
    push = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        cc_n = '0;
        if (r3 && !r2) begin
          state_n = START;
          d_n = div;
        end
      end
      START: if (cc == (d >> 1) - 16'd1) begin
        cc_n = '0;
        bc_n = '0;
        state_n = r2 ? IDLE : DATA;
      end
      DATA: if (cc == d - 16'd1) begin
        cc_n = '0;
        sh_n = {r2, sh[7:1]};
        bc_n = bc + 3'd1;
        if (bc == 3'd7) begin
          state_n = STOP;
          fw_n = 1'b0;
        end
      end
      STOP: if (fw) begin
        // broken stop bit: hold off until the line returns to idle
        cc_n = '0;
        if (r2) begin
          state_n = IDLE;
          fw_n = 1'b0;
        end
      end else if (cc == d - 16'd1) begin
        cc_n = '0;
        if (r2) begin
          push = 1'b1;
          state_n = IDLE;
        end else begin
          ferr_set = 1'b1;
          fw_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      {r1, r2, r3} <= 3'b111;
      state <= IDLE;
      cc <= '0;
      bc <= '0;
      sh <= '0;
      d <= 16'(DEFAULT_DIV);
      fw <= 1'b0;
    end else begin
      {r1, r2, r3} <= {rxd, r1, r2};
      state <= state_n;
      cc <= cc_n;
      bc <= bc_n;
      sh <= sh_n;
      d <= d_n;
      fw <= fw_n;
    end
  end
  always_comb rmux = a == 2'd0 ? (empty ? 32'd0 : {23'd0, 1'b1, mem[rp]}) :
                     a == 2'd1 ? {20'd0, ferr, ovr, full, empty, 3'd0, 5'(count)} :
                     a == 2'd2 ? {16'd0, div} : {27'd0, thresh};
  always_ff @(posedge clk) if (acc) mem[wp] <= sh;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ovr <= 1'b0;
      ferr <= 1'b0;
      div <= 16'(DEFAULT_DIV);
      thresh <= 5'd1;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      irq <= 1'b0;
    end else begin
      mem_ready <= req;
      mem_rdata <= (req && !wr) ? rmux : '0;
      irq <= thresh != 5'd0 && 32'(count) >= 32'(thresh);
      if (acc) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (FIFO_AW+1)'(acc) - (FIFO_AW+1)'(pop);
      ovr <= (ovr && !(req && wr && a == 2'd1 && mem_wdata[10])) || (push && !acc);
      ferr <= (ferr && !(req && wr && a == 2'd1 && mem_wdata[11])) || ferr_set;
      if (req && wr && a == 2'd2) div <= mem_wdata[15:0] < 16'd4 ? 16'd4 : mem_wdata[15:0];
      if (req && wr && a == 2'd3) thresh <= mem_wdata[4:0];
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo_mmio.sv
// tb_uart_rx_fifo_mmio: directed bench with a queue-based model of the receiver's register view
module tb_uart_rx_fifo_mmio;
  logic clk = 1'b0, resetn = 1'b0, mem_valid = 1'b0, rxd = 1'b1;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0] mem_wstrb = '0;
  logic mem_ready, irq;
  logic [31:0] mem_rdata;
  int n_vec = 0, n_err = 0;
  byte unsigned q[$];
  logic m_ovr = 1'b0, m_ferr = 1'b0;
  int m_div = 50;
  logic [4:0] m_thresh = 5'd1;
  logic busy = 1'b1, exp_valid = 1'b0, prev_ready = 1'b0;
  logic [31:0] exp_rd = '0, r;

  always #5 clk = ~clk;

  uart_rx_fifo_mmio dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .rxd(rxd), .irq(irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_irq();
    return m_thresh != 5'd0 && q.size() >= int'(m_thresh);
  endfunction

  function automatic logic [31:0] m_status();
    return {20'd0, m_ferr, m_ovr, q.size() == 16, q.size() == 0, 3'd0, 5'(q.size())};
  endfunction

  always @(negedge clk) begin
    if (resetn) begin
      if (mem_ready && exp_valid) chk("rdata", mem_rdata, exp_rd);
      else if (!mem_ready) chk("rdata_idle", mem_rdata, 32'd0);
      chk("ready_pulse", {31'd0, mem_ready & prev_ready}, 32'd0);
      if (!busy) chk("irq", {31'd0, irq}, {31'd0, m_irq()});
      prev_ready = mem_ready;
    end else prev_ready = 1'b0;
  end

  task automatic bus(input logic [1:0] a, input logic [31:0] wd, input logic [3:0] ws, output logic [31:0] rd);
    busy = 1'b1;
    @(negedge clk);
    if (ws == 4'd0) begin
      exp_valid = 1'b1;
      exp_rd = a == 2'd0 ? (q.size() != 0 ? {23'd0, 1'b1, q[0]} : 32'd0) :
               a == 2'd1 ? m_status() :
               a == 2'd2 ? 32'(m_div) : {27'd0, m_thresh};
      if (a == 2'd0 && q.size() != 0) void'(q.pop_front());
    end else begin
      exp_valid = 1'b0;
      if (a == 2'd1 && wd[10]) m_ovr = 1'b0;
      if (a == 2'd1 && wd[11]) m_ferr = 1'b0;
      if (a == 2'd2) m_div = wd[15:0] < 16'd4 ? 4 : int'(wd[15:0]);
      if (a == 2'd3) m_thresh = wd[4:0];
    end
    mem_valid = 1'b1;
    mem_addr = 32'h8000_0010 | {28'd0, a, 2'd0};
    mem_wdata = wd;
    mem_wstrb = ws;
    @(negedge clk);
    chk("ready_latency", {31'd0, mem_ready}, 32'd1);
    rd = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    repeat (2) @(negedge clk);
    busy = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int stop_low);
    logic [8:0] f;
    f = {b, 1'b0};
    busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rxd = f[i];
      repeat (m_div) @(negedge clk);
    end
    if (stop_low > 0) begin
      rxd = 1'b0;
      repeat (stop_low) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (2 * m_div + 6) @(negedge clk);
    if (stop_low > 0) m_ferr = 1'b1;
    else if (q.size() < 16) q.push_back(b);
    else m_ovr = 1'b1;
    busy = 1'b0;
  endtask

  task automatic do_reset();
    busy = 1'b1;
    resetn = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    m_div = 50;
    m_thresh = 5'd1;
    repeat (2) @(negedge clk);
    busy = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    chk("rst_irq", {31'd0, irq}, 32'd0);
    bus(2'd1, 0, 0, r); chk("rst_status", r, 32'h0000_0100);
    bus(2'd2, 0, 0, r); chk("rst_div", r, 32'h32);
    bus(2'd3, 0, 0, r); chk("rst_thresh", r, 32'h1);
    send(8'hA5, 0);
    chk("irq_one_byte", {31'd0, irq}, 32'd1);
    bus(2'd0, 0, 0, r); chk("data_a5", r, 32'h0000_01A5);
    bus(2'd0, 0, 0, r); chk("data_empty", r, 32'h0);
    bus(2'd1, 0, 0, r); chk("status_empty", r, 32'h0000_0100);
    bus(2'd2, 32'd2, 4'b0001, r);
    bus(2'd2, 0, 0, r); chk("div_min", r, 32'h4);
    send(8'h3C, 0);
    bus(2'd0, 0, 0, r); chk("data_3c", r, 32'h0000_013C);
    bus(2'd3, 32'd3, 4'b1111, r);
    send(8'h11, 0);
    send(8'h22, 0);
    chk("irq_below", {31'd0, irq}, 32'd0);
    send(8'h33, 0);
    chk("irq_at", {31'd0, irq}, 32'd1);
    bus(2'd0, 0, 0, r); chk("data_11", r, 32'h0000_0111);
    chk("irq_drop", {31'd0, irq}, 32'd0);
    bus(2'd0, 0, 0, r); chk("data_22", r, 32'h0000_0122);
    bus(2'd0, 0, 0, r); chk("data_33", r, 32'h0000_0133);
    for (int i = 0; i < 17; i++) send(8'(i * 7 + 1), 0);
    bus(2'd1, 0, 0, r); chk("status_full", r, 32'h0000_0610);
    for (int i = 0; i < 16; i++) begin
      bus(2'd0, 0, 0, r);
      chk("fifo_order", r, {23'd0, 1'b1, 8'(i * 7 + 1)});
    end
    bus(2'd1, 32'h400, 4'b0010, r);
    bus(2'd1, 0, 0, r); chk("ovr_clear", r, 32'h0000_0100);
    bus(2'd2, 32'h32, 4'b1000, r);
    bus(2'd2, 0, 0, r); chk("div_lane", r, 32'h32);
    send(8'h55, 50);
    bus(2'd1, 0, 0, r); chk("frame_err", r, 32'h0000_0900);
    bus(2'd1, 32'h800, 4'b0010, r);
    bus(2'd1, 0, 0, r); chk("ferr_clear", r, 32'h0000_0100);
    busy = 1'b1;
    rxd = 1'b0;
    repeat (25) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    busy = 1'b0;
    bus(2'd1, 0, 0, r); chk("glitch", r, 32'h0000_0100);
    bus(2'd2, 32'd8, 4'b0001, r);
    busy = 1'b1;
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    do_reset();
    bus(2'd1, 0, 0, r); chk("midframe_status", r, 32'h0000_0100);
    bus(2'd2, 0, 0, r); chk("midframe_div", r, 32'h32);
    send(8'h96, 0);
    bus(2'd0, 0, 0, r); chk("data_96", r, 32'h0000_0196);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
